// File: rtl/arbiter_out_node_if.sv
// Upload-side bundle of the communication assist: four upload sources in,
// two registered ring channels (req, rep) out.
interface arbiter_out_node_if #(
   parameter int unsigned FLIT_W = 16,
   parameter int unsigned CTRL_W = 2
);
   logic              v_ic_req;
   logic [FLIT_W-1:0] ic_req_flit;
   logic [CTRL_W-1:0] ic_req_ctrl;
   logic              ack_ic_req;
   logic              v_dc_req;
   logic [FLIT_W-1:0] dc_req_flit;
   logic [CTRL_W-1:0] dc_req_ctrl;
   logic              ack_dc_req;
   logic              v_dc_rep;
   logic [FLIT_W-1:0] dc_rep_flit;
   logic [CTRL_W-1:0] dc_rep_ctrl;
   logic              ack_dc_rep;
   logic              v_mem_rep;
   logic [FLIT_W-1:0] mem_rep_flit;
   logic [CTRL_W-1:0] mem_rep_ctrl;
   logic              ack_mem_rep;
   logic              out_req_rdy;
   logic              v_req_out;
   logic [FLIT_W-1:0] req_flit_out;
   logic [CTRL_W-1:0] req_ctrl_out;
   logic              out_rep_rdy;
   logic              v_rep_out;
   logic [FLIT_W-1:0] rep_flit_out;
   logic [CTRL_W-1:0] rep_ctrl_out;

   modport master (
      output v_ic_req, ic_req_flit, ic_req_ctrl, input ack_ic_req,
      output v_dc_req, dc_req_flit, dc_req_ctrl, input ack_dc_req,
      output v_dc_rep, dc_rep_flit, dc_rep_ctrl, input ack_dc_rep,
      output v_mem_rep, mem_rep_flit, mem_rep_ctrl, input ack_mem_rep,
      output out_req_rdy, input v_req_out, req_flit_out, req_ctrl_out,
      output out_rep_rdy, input v_rep_out, rep_flit_out, rep_ctrl_out
   );

   modport slave (
      input v_ic_req, ic_req_flit, ic_req_ctrl, output ack_ic_req,
      input v_dc_req, dc_req_flit, dc_req_ctrl, output ack_dc_req,
      input v_dc_rep, dc_rep_flit, dc_rep_ctrl, output ack_dc_rep,
      input v_mem_rep, mem_rep_flit, mem_rep_ctrl, output ack_mem_rep,
      input out_req_rdy, output v_req_out, req_flit_out, req_ctrl_out,
      input out_rep_rdy, output v_rep_out, rep_flit_out, rep_ctrl_out
   );
endinterface

// File: rtl/arbiter_out_node.sv
// Packet-locked round-robin arbiter merging upload flits onto the req (ic/dc)
// and rep (dc/mem) ring channels, each with a one-flit output register.
module arbiter_out_node #(
   parameter int unsigned FLIT_W = 16,
   parameter int unsigned CTRL_W = 2
) (
   input logic               clk,
   input logic               rst,
   arbiter_out_node_if.slave bus
);
   localparam logic [CTRL_W-1:0] CtrlHead = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] CtrlTail = CTRL_W'(3);

   typedef enum logic [2:0] {
      StIdle = 3'b001,
      StA    = 3'b010,
      StB    = 3'b100
   } state_e;

   // Index 0 is the req channel (A=ic, B=dc), index 1 the rep channel (A=dc, B=mem).
   logic [1:0]        v_a, v_b, rdy, ack_a, ack_b, v_out;
   logic [FLIT_W-1:0] flit_a [2];
   logic [FLIT_W-1:0] flit_b [2];
   logic [FLIT_W-1:0] flit_out [2];
   logic [CTRL_W-1:0] ctrl_a [2];
   logic [CTRL_W-1:0] ctrl_b [2];
   logic [CTRL_W-1:0] ctrl_out [2];

   assign v_a       = {bus.v_dc_rep, bus.v_ic_req};
   assign v_b       = {bus.v_mem_rep, bus.v_dc_req};
   assign rdy       = {bus.out_rep_rdy, bus.out_req_rdy};
   assign flit_a[0] = bus.ic_req_flit;
   assign flit_a[1] = bus.dc_rep_flit;
   assign flit_b[0] = bus.dc_req_flit;
   assign flit_b[1] = bus.mem_rep_flit;
   assign ctrl_a[0] = bus.ic_req_ctrl;
   assign ctrl_a[1] = bus.dc_rep_ctrl;
   assign ctrl_b[0] = bus.dc_req_ctrl;
   assign ctrl_b[1] = bus.mem_rep_ctrl;

   for (genvar c = 0; c < 2; c++) begin : g_ch
      state_e            state_q, state_d;
      logic              prio_a_q, prio_a_d;
      logic              v_out_q;
      logic [FLIT_W-1:0] flit_q;
      logic [CTRL_W-1:0] ctrl_q;
      logic              ld, head_a, head_b, grant_a, grant_b, load, sel_b;

      assign ld     = !v_out_q || rdy[c];
      assign head_a = v_a[c] && (ctrl_a[c] == CtrlHead);
      assign head_b = v_b[c] && (ctrl_b[c] == CtrlHead);

      always_comb begin
         state_d  = state_q;
         prio_a_d = prio_a_q;
         grant_a  = 1'b0;
         grant_b  = 1'b0;
         load     = 1'b0;
         sel_b    = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ld && head_a && (prio_a_q || !head_b)) begin
                  grant_a = 1'b1;
                  load    = 1'b1;
                  state_d = StA;
               end else if (ld && head_b) begin
                  grant_b = 1'b1;
                  load    = 1'b1;
                  sel_b   = 1'b1;
                  state_d = StB;
               end
               // Orphan body/tail flits with no open packet are consumed and dropped.
               if (v_a[c] && !head_a) grant_a = 1'b1;
               if (v_b[c] && !head_b) grant_b = 1'b1;
            end
            StA: begin
               if (v_a[c] && ld) begin
                  grant_a = 1'b1;
                  load    = 1'b1;
                  if (ctrl_a[c] == CtrlTail) begin
                     state_d  = StIdle;
                     prio_a_d = 1'b0;
                  end
               end
            end
            StB: begin
               if (v_b[c] && ld) begin
                  grant_b = 1'b1;
                  load    = 1'b1;
                  sel_b   = 1'b1;
                  if (ctrl_b[c] == CtrlTail) begin
                     state_d  = StIdle;
                     prio_a_d = 1'b1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q  <= StIdle;
            prio_a_q <= 1'b1;
            v_out_q  <= 1'b0;
            flit_q   <= '0;
            ctrl_q   <= '0;
         end else begin
            state_q  <= state_d;
            prio_a_q <= prio_a_d;
            if (load) begin
               v_out_q <= 1'b1;
               flit_q  <= sel_b ? flit_b[c] : flit_a[c];
               ctrl_q  <= sel_b ? ctrl_b[c] : ctrl_a[c];
            end else if (rdy[c]) begin
               v_out_q <= 1'b0;
            end
         end
      end

      // Acks are combinational, so gate them while reset is asserted.
      assign ack_a[c]    = grant_a && rst;
      assign ack_b[c]    = grant_b && rst;
      assign v_out[c]    = v_out_q;
      assign flit_out[c] = flit_q;
      assign ctrl_out[c] = ctrl_q;
   end

   assign bus.ack_ic_req   = ack_a[0];
   assign bus.ack_dc_req   = ack_b[0];
   assign bus.ack_dc_rep   = ack_a[1];
   assign bus.ack_mem_rep  = ack_b[1];
   assign bus.v_req_out    = v_out[0];
   assign bus.req_flit_out = flit_out[0];
   assign bus.req_ctrl_out = ctrl_out[0];
   assign bus.v_rep_out    = v_out[1];
   assign bus.rep_flit_out = flit_out[1];
   assign bus.rep_ctrl_out = ctrl_out[1];
endmodule

// File: tb/tb_arbiter_out_node.sv
// Directed vector bench for arbiter_out_node: per-cycle table of source
// inputs, ring readies, expected acks and expected registered outputs.
module tb_arbiter_out_node;
   localparam int unsigned FlitW = 16;
   localparam int unsigned CtrlW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arbiter_out_node_if #(.FLIT_W(FlitW), .CTRL_W(CtrlW)) bus ();

   arbiter_out_node #(.FLIT_W(FlitW), .CTRL_W(CtrlW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Source fields ordered {ic_req, dc_req, dc_rep, mem_rep}; rdy is {req, rep};
   // oq/op are {v_out, ctrl_out, flit_out}, flit/ctrl ignored when v_out is 0.
   typedef struct {
      logic [3:0]  v;
      logic [7:0]  c;
      logic [63:0] f;
      logic [1:0]  rdy;
      logic [3:0]  ack;
      logic [18:0] oq;
      logic [18:0] op;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic [3:0] v, input logic [7:0] c, input logic [63:0] f,
                               input logic [1:0] rdy, input logic [3:0] ack,
                               input logic [18:0] oq, input logic [18:0] op);
      vec_t t;
      t.v = v; t.c = c; t.f = f; t.rdy = rdy; t.ack = ack; t.oq = oq; t.op = op;
      return t;
   endfunction

   task automatic drive(input vec_t t);
      bus.v_ic_req     = t.v[3];
      bus.ic_req_ctrl  = t.c[7:6];
      bus.ic_req_flit  = t.f[63:48];
      bus.v_dc_req     = t.v[2];
      bus.dc_req_ctrl  = t.c[5:4];
      bus.dc_req_flit  = t.f[47:32];
      bus.v_dc_rep     = t.v[1];
      bus.dc_rep_ctrl  = t.c[3:2];
      bus.dc_rep_flit  = t.f[31:16];
      bus.v_mem_rep    = t.v[0];
      bus.mem_rep_ctrl = t.c[1:0];
      bus.mem_rep_flit = t.f[15:0];
      bus.out_req_rdy  = t.rdy[1];
      bus.out_rep_rdy  = t.rdy[0];
   endtask

   task automatic check_out(input string name, input string ch, input logic [18:0] got,
                            input logic [18:0] want);
      n_cmp++;
      if (got[18] !== want[18] || (want[18] && got !== want)) begin
         n_err++;
         $display("FAIL %s %s out {v,ctrl,flit}: got %h want %h", name, ch, got, want);
      end
   endtask

   task automatic check(input string name, input vec_t t);
      logic [3:0] ack;
      ack = {bus.ack_ic_req, bus.ack_dc_req, bus.ack_dc_rep, bus.ack_mem_rep};
      n_cmp++;
      if (ack !== t.ack) begin
         n_err++;
         $display("FAIL %s ack {ic,dcq,dcp,mem}: got %b want %b", name, ack, t.ack);
      end
      check_out(name, "req", {bus.v_req_out, bus.req_ctrl_out, bus.req_flit_out}, t.oq);
      check_out(name, "rep", {bus.v_rep_out, bus.rep_ctrl_out, bus.rep_flit_out}, t.op);
   endtask

   task automatic check_zero(input string name);
      logic [41:0] got;
      got = {bus.ack_ic_req, bus.ack_dc_req, bus.ack_dc_rep, bus.ack_mem_rep,
             bus.v_req_out, bus.req_ctrl_out, bus.req_flit_out,
             bus.v_rep_out, bus.rep_ctrl_out, bus.rep_flit_out};
      n_cmp++;
      if (got !== 42'h0) begin
         n_err++;
         $display("FAIL %s all-zero outputs: got %h want 0", name, got);
      end
   endtask

   task automatic run_row(input string name, input vec_t t);
      @(negedge clk);
      drive(t);
      #1;
      check(name, t);
   endtask

   initial begin
      rst = 1'b0;
      drive(mk(4'h0, 8'h0, 64'h0, 2'b11, 4'h0, 19'h0, 19'h0));
      repeat (2) @(negedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // Contention on req: ic wins first, then dc, then ic again (round-robin).
      vecs.push_back(mk(4'b1100, 8'b01_01_00_00, 64'hA001_D001_0000_0000, 2'b11, 4'b1000, 19'h0, 19'h0));
      vecs.push_back(mk(4'b1100, 8'b10_01_00_00, 64'hA002_D001_0000_0000, 2'b11, 4'b1000, 19'h5A001, 19'h0));
      vecs.push_back(mk(4'b1100, 8'b11_01_00_00, 64'hA003_D001_0000_0000, 2'b11, 4'b1000, 19'h6A002, 19'h0));
      vecs.push_back(mk(4'b1100, 8'b01_01_00_00, 64'hA101_D001_0000_0000, 2'b11, 4'b0100, 19'h7A003, 19'h0));
      vecs.push_back(mk(4'b1100, 8'b01_10_00_00, 64'hA101_D002_0000_0000, 2'b11, 4'b0100, 19'h5D001, 19'h0));
      vecs.push_back(mk(4'b1100, 8'b01_11_00_00, 64'hA101_D003_0000_0000, 2'b11, 4'b0100, 19'h6D002, 19'h0));
      vecs.push_back(mk(4'b1100, 8'b01_01_00_00, 64'hA101_D101_0000_0000, 2'b11, 4'b1000, 19'h7D003, 19'h0));
      vecs.push_back(mk(4'b1100, 8'b10_01_00_00, 64'hA102_D101_0000_0000, 2'b11, 4'b1000, 19'h5A101, 19'h0));
      vecs.push_back(mk(4'b1100, 8'b11_01_00_00, 64'hA103_D101_0000_0000, 2'b11, 4'b1000, 19'h6A102, 19'h0));
      vecs.push_back(mk(4'b0100, 8'b00_01_00_00, 64'h0000_D101_0000_0000, 2'b11, 4'b0100, 19'h7A103, 19'h0));
      vecs.push_back(mk(4'b0100, 8'b00_11_00_00, 64'h0000_D102_0000_0000, 2'b11, 4'b0100, 19'h5D101, 19'h0));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h7D102, 19'h0));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h0));
      // Single ic packet.
      vecs.push_back(mk(4'b1000, 8'b01_00_00_00, 64'h4A00_0000_0000_0000, 2'b11, 4'b1000, 19'h0, 19'h0));
      vecs.push_back(mk(4'b1000, 8'b10_00_00_00, 64'h1111_0000_0000_0000, 2'b11, 4'b1000, 19'h54A00, 19'h0));
      vecs.push_back(mk(4'b1000, 8'b11_00_00_00, 64'h2222_0000_0000_0000, 2'b11, 4'b1000, 19'h61111, 19'h0));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h72222, 19'h0));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h0));
      // dc_rep packet with a 3-cycle rep stall mid-packet.
      vecs.push_back(mk(4'b0010, 8'b00_00_01_00, 64'h0000_0000_C000_0000, 2'b11, 4'b0010, 19'h0, 19'h0));
      vecs.push_back(mk(4'b0010, 8'b00_00_10_00, 64'h0000_0000_C001_0000, 2'b11, 4'b0010, 19'h0, 19'h5C000));
      vecs.push_back(mk(4'b0010, 8'b00_00_10_00, 64'h0000_0000_C002_0000, 2'b10, 4'b0000, 19'h0, 19'h6C001));
      vecs.push_back(mk(4'b0010, 8'b00_00_10_00, 64'h0000_0000_C002_0000, 2'b10, 4'b0000, 19'h0, 19'h6C001));
      vecs.push_back(mk(4'b0010, 8'b00_00_10_00, 64'h0000_0000_C002_0000, 2'b10, 4'b0000, 19'h0, 19'h6C001));
      vecs.push_back(mk(4'b0010, 8'b00_00_10_00, 64'h0000_0000_C002_0000, 2'b11, 4'b0010, 19'h0, 19'h6C001));
      vecs.push_back(mk(4'b0010, 8'b00_00_11_00, 64'h0000_0000_C003_0000, 2'b11, 4'b0010, 19'h0, 19'h6C002));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h7C003));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h0));
      // dc req packet and mem rep packet in parallel.
      vecs.push_back(mk(4'b0101, 8'b00_01_00_01, 64'h0000_E000_0000_F000, 2'b11, 4'b0101, 19'h0, 19'h0));
      vecs.push_back(mk(4'b0101, 8'b00_11_00_10, 64'h0000_E001_0000_F001, 2'b11, 4'b0101, 19'h5E000, 19'h5F000));
      vecs.push_back(mk(4'b0001, 8'b00_00_00_11, 64'h0000_0000_0000_F002, 2'b11, 4'b0001, 19'h7E001, 19'h6F001));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h7F002));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h0));
      // Orphan body flit on idle rep channel.
      vecs.push_back(mk(4'b0001, 8'b00_00_00_10, 64'h0000_0000_0000_BEEF, 2'b11, 4'b0001, 19'h0, 19'h0));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h0));
      // Idle head held off while the output stage is stalled (ld=0).
      vecs.push_back(mk(4'b0001, 8'b00_00_00_01, 64'h0000_0000_0000_BA00, 2'b11, 4'b0001, 19'h0, 19'h0));
      vecs.push_back(mk(4'b0001, 8'b00_00_00_11, 64'h0000_0000_0000_BA01, 2'b11, 4'b0001, 19'h0, 19'h5BA00));
      vecs.push_back(mk(4'b0010, 8'b00_00_01_00, 64'h0000_0000_BB00_0000, 2'b10, 4'b0000, 19'h0, 19'h7BA01));
      vecs.push_back(mk(4'b0010, 8'b00_00_01_00, 64'h0000_0000_BB00_0000, 2'b11, 4'b0010, 19'h0, 19'h7BA01));
      vecs.push_back(mk(4'b0010, 8'b00_00_11_00, 64'h0000_0000_BB01_0000, 2'b11, 4'b0010, 19'h0, 19'h5BB00));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h7BB01));
      vecs.push_back(mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h0));

      for (int i = 0; i < vecs.size(); i++) run_row($sformatf("row%0d", i), vecs[i]);

      // Async reset mid mem packet after the rep priority has moved to mem.
      run_row("rst_x0", mk(4'b0010, 8'b00_00_01_00, 64'h0000_0000_7000_0000, 2'b11, 4'b0010, 19'h0, 19'h0));
      run_row("rst_x1", mk(4'b0010, 8'b00_00_11_00, 64'h0000_0000_7001_0000, 2'b11, 4'b0010, 19'h0, 19'h57000));
      run_row("rst_x2", mk(4'b0001, 8'b00_00_00_01, 64'h0000_0000_0000_8000, 2'b11, 4'b0001, 19'h0, 19'h77001));
      run_row("rst_x3", mk(4'b0001, 8'b00_00_00_10, 64'h0000_0000_0000_8001, 2'b11, 4'b0001, 19'h0, 19'h58000));
      @(negedge clk);
      drive(mk(4'b0001, 8'b00_00_00_11, 64'h0000_0000_0000_8002, 2'b11, 4'b0, 19'h0, 19'h0));
      #2;
      rst = 1'b0;
      #1;
      check_zero("rst_mid");
      @(negedge clk);
      check_zero("rst_hold");
      rst = 1'b1;
      drive(mk(4'b0011, 8'b00_00_01_01, 64'h0000_0000_9000_8100, 2'b11, 4'b0010, 19'h0, 19'h0));
      #1;
      check("rst_x5", mk(4'b0011, 8'b00_00_01_01, 64'h0000_0000_9000_8100, 2'b11, 4'b0010, 19'h0, 19'h0));
      run_row("rst_x6", mk(4'b0011, 8'b00_00_11_01, 64'h0000_0000_9001_8100, 2'b11, 4'b0010, 19'h0, 19'h59000));
      run_row("rst_x7", mk(4'b0000, 8'h0, 64'h0, 2'b11, 4'b0000, 19'h0, 19'h79001));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
